ebm_md_rx: RTL and testbench

Egress-buffer read engine at the EBM end of the EOS metadata interface. It accepts the 8-bit scheduled metadata and bandwidth-discard flag issued by EOS, then reads the packet from the shared packet buffer and streams it to UDO output port 0 or 1. It returns the buffer ID to the free pool and pulses packet-valid back to EOS for each packet actually transmitted.

---
 rtl/ebm_md_rx.sv | 146 ++++++++++++++
 tb/tb_ebm_md_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebm_md_rx.sv
// ebm_md_rx: queues EOS metadata, reads each packet from the egress buffer, streams it to UDO port 0/1 and frees the buffer
module ebm_md_rx #(
    parameter int MD_FIFO_DEPTH = 8,
    parameter int START_THRESH  = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_ebm_md,
    input  logic         in_ebm_md_wr,
    input  logic         in_ebm_bandwidth_discard,
    output logic         out_ebm_pkt_valid,
    output logic         out_ebm_buf_rd,
    output logic [13:0]  out_ebm_buf_rd_addr,
    input  logic [133:0] in_ebm_buf_rd_data,
    output logic [6:0]   out_ebm_buf_free_id,
    output logic         out_ebm_buf_free_wr,
    output logic [133:0] out_ebm_pkt_0,
    output logic         out_ebm_pkt_0_wr,
    output logic [133:0] out_ebm_pkt_1,
    output logic         out_ebm_pkt_1_wr,
    input  logic [7:0]   pktout_usedw_0,
    input  logic [7:0]   pktout_usedw_1,
    output logic [63:0]  out_ebm_tx_pkt_cnt,
    output logic [63:0]  out_ebm_discard_cnt,
    output logic [31:0]  out_ebm_md_ovf_cnt
);
    localparam int AW = $clog2(MD_FIFO_DEPTH);
    localparam logic [8:0] THRESH = 9'(START_THRESH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_t;

    state_t        state_q;
    logic [8:0]    fifo_mem [MD_FIFO_DEPTH];
    logic [AW:0]   wp_q, rp_q;
    logic [6:0]    id_q, off_q;
    logic          port_q, done_q, rd_end_q;
    logic [1:0]    rv_q, lv_q;
    logic [8:0]    head;
    logic [7:0]    usedw_sel;
    logic          empty, full, pop, push, rd, gated, is_tail;
    logic [133:0]  word;

    assign empty     = wp_q == rp_q;
    assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign head      = fifo_mem[rp_q[AW-1:0]];
    assign usedw_sel = head[7] ? pktout_usedw_1 : pktout_usedw_0;
    assign pop       = (state_q == IDLE) && !empty && (head[8] || ({1'b0, usedw_sel} < THRESH));
    assign push      = in_ebm_md_wr && (!full || pop);
    // the word returned for offset 127 is forced to a tail so an unterminated buffer still ends
    assign word      = lv_q[1] ? {2'b10, in_ebm_buf_rd_data[131:0]} : in_ebm_buf_rd_data;
    assign gated     = rv_q[1] && !done_q;
    assign is_tail   = word[133:132] == 2'b10;
    // reading stops in the very cycle the tail comes back so only one extra read is in flight
    assign rd        = (state_q == READ) && !rd_end_q && !(gated && is_tail);

    assign out_ebm_buf_rd      = rd;
    assign out_ebm_buf_rd_addr = {id_q, off_q};

    // metadata storage, no reset needed since pointers qualify every entry
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wp_q[AW-1:0]] <= {in_ebm_bandwidth_discard, in_ebm_md};
    end

    // FIFO pointers and overflow count; a pop frees room for a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q               <= '0;
            rp_q               <= '0;
            out_ebm_md_ovf_cnt <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            if (in_ebm_md_wr && !push) out_ebm_md_ovf_cnt <= out_ebm_md_ovf_cnt + 32'd1;
        end
    end

    // read engine: state, read pipeline tracking, packet output and release pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            id_q                <= '0;
            off_q               <= '0;
            port_q              <= 1'b0;
            done_q              <= 1'b0;
            rd_end_q            <= 1'b0;
            rv_q                <= '0;
            lv_q                <= '0;
            out_ebm_pkt_valid   <= 1'b0;
            out_ebm_buf_free_id <= '0;
            out_ebm_buf_free_wr <= 1'b0;
            out_ebm_pkt_0       <= '0;
            out_ebm_pkt_0_wr    <= 1'b0;
            out_ebm_pkt_1       <= '0;
            out_ebm_pkt_1_wr    <= 1'b0;
            out_ebm_tx_pkt_cnt  <= '0;
            out_ebm_discard_cnt <= '0;
        end else begin
            out_ebm_pkt_valid   <= 1'b0;
            out_ebm_buf_free_wr <= 1'b0;
            out_ebm_pkt_0_wr    <= 1'b0;
            out_ebm_pkt_1_wr    <= 1'b0;
            rv_q                <= {rv_q[0], rd};
            lv_q                <= {lv_q[0], rd && (off_q == 7'h7f)};
            if (gated) begin
                if (port_q) begin
                    out_ebm_pkt_1    <= word;
                    out_ebm_pkt_1_wr <= 1'b1;
                end else begin
                    out_ebm_pkt_0    <= word;
                    out_ebm_pkt_0_wr <= 1'b1;
                end
                if (is_tail) done_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (pop) begin
                    id_q <= head[6:0];
                    if (head[8]) begin
                        out_ebm_buf_free_wr <= 1'b1;
                        out_ebm_buf_free_id <= head[6:0];
                        out_ebm_discard_cnt <= out_ebm_discard_cnt + 64'd1;
                        state_q             <= RELEASE;
                    end else begin
                        port_q   <= head[7];
                        off_q    <= '0;
                        done_q   <= 1'b0;
                        rd_end_q <= 1'b0;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    if (rd) off_q <= off_q + 7'd1;
                    if (rd && off_q == 7'h7f) rd_end_q <= 1'b1;
                    if (gated && is_tail) state_q <= DRAIN;
                end
                DRAIN: if (rv_q == 2'b00) begin
                    out_ebm_buf_free_wr <= 1'b1;
                    out_ebm_buf_free_id <= id_q;
                    out_ebm_pkt_valid   <= 1'b1;
                    out_ebm_tx_pkt_cnt  <= out_ebm_tx_pkt_cnt + 64'd1;
                    state_q             <= RELEASE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ebm_md_rx.sv
// tb_ebm_md_rx: scoreboard bench for the egress-buffer read engine
module tb_ebm_md_rx;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_ebm_md = '0;
    logic         in_ebm_md_wr = 1'b0;
    logic         in_ebm_bandwidth_discard = 1'b0;
    logic         out_ebm_pkt_valid;
    logic         out_ebm_buf_rd;
    logic [13:0]  out_ebm_buf_rd_addr;
    logic [133:0] in_ebm_buf_rd_data;
    logic [6:0]   out_ebm_buf_free_id;
    logic         out_ebm_buf_free_wr;
    logic [133:0] out_ebm_pkt_0, out_ebm_pkt_1;
    logic         out_ebm_pkt_0_wr, out_ebm_pkt_1_wr;
    logic [7:0]   pktout_usedw_0 = '0, pktout_usedw_1 = '0;
    logic [63:0]  out_ebm_tx_pkt_cnt, out_ebm_discard_cnt;
    logic [31:0]  out_ebm_md_ovf_cnt;

    ebm_md_rx dut (
        .clk(clk), .rst_n(rst_n),
        .in_ebm_md(in_ebm_md), .in_ebm_md_wr(in_ebm_md_wr),
        .in_ebm_bandwidth_discard(in_ebm_bandwidth_discard),
        .out_ebm_pkt_valid(out_ebm_pkt_valid),
        .out_ebm_buf_rd(out_ebm_buf_rd), .out_ebm_buf_rd_addr(out_ebm_buf_rd_addr),
        .in_ebm_buf_rd_data(in_ebm_buf_rd_data),
        .out_ebm_buf_free_id(out_ebm_buf_free_id), .out_ebm_buf_free_wr(out_ebm_buf_free_wr),
        .out_ebm_pkt_0(out_ebm_pkt_0), .out_ebm_pkt_0_wr(out_ebm_pkt_0_wr),
        .out_ebm_pkt_1(out_ebm_pkt_1), .out_ebm_pkt_1_wr(out_ebm_pkt_1_wr),
        .pktout_usedw_0(pktout_usedw_0), .pktout_usedw_1(pktout_usedw_1),
        .out_ebm_tx_pkt_cnt(out_ebm_tx_pkt_cnt), .out_ebm_discard_cnt(out_ebm_discard_cnt),
        .out_ebm_md_ovf_cnt(out_ebm_md_ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, t_md = 0, t = 0, tu = 0;
    int head_cyc = 0, tail_cyc = 0, free_cyc = 0, rd_start = 0, w0 = 0, w1 = 0;
    logic rd_prev = 1'b0;
    longint tx_exp = 0, disc_exp = 0, ovf_exp = 0;
    logic [133:0] exp0[$], exp1[$];
    logic [7:0]   expf[$];
    int blen[128];
    logic [13:0]  a1 = '0;
    logic [133:0] rdata = '0;

    task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // buffer contents: length 0 means the buffer never carries a tail
    function automatic logic [133:0] word(input logic [6:0] id, input logic [6:0] off);
        int len = blen[id];
        logic [1:0] f;
        f = (off == 0) ? 2'b01 : (len != 0 && int'(off) == len - 1) ? 2'b10 : 2'b11;
        return {f, (f == 2'b10) ? 4'(len) : 4'h0, id, off, 114'(int'(id) * 1000 + int'(off))};
    endfunction

    task automatic push_pkt(input logic [6:0] id, input logic port, input logic disc);
        logic [133:0] w;
        int n;
        if (disc) begin
            expf.push_back({1'b0, id});
            disc_exp++;
        end else begin
            n = (blen[id] == 0) ? 128 : blen[id];
            for (int i = 0; i < n; i++) begin
                w = word(id, 7'(i));
                if (i == 127) w[133:132] = 2'b10;
                if (port) exp1.push_back(w);
                else exp0.push_back(w);
            end
            expf.push_back({1'b1, id});
            tx_exp++;
        end
    endtask

    task automatic send(input logic [7:0] md, input logic disc);
        @(negedge clk);
        in_ebm_md = md;
        in_ebm_bandwidth_discard = disc;
        in_ebm_md_wr = 1'b1;
        t_md = cyc;
    endtask

    task automatic stop();
        @(negedge clk);
        in_ebm_md_wr = 1'b0;
        in_ebm_bandwidth_discard = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && (exp0.size() + exp1.size() + expf.size()) != 0; i++) @(negedge clk);
        chk(tag, exp0.size() + exp1.size() + expf.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ctl"}, {out_ebm_pkt_valid, out_ebm_buf_rd, out_ebm_buf_rd_addr, out_ebm_buf_free_id,
                            out_ebm_buf_free_wr, out_ebm_pkt_0_wr, out_ebm_pkt_1_wr}, 0);
        chk({tag, "_p0"}, out_ebm_pkt_0, 0);
        chk({tag, "_p1"}, out_ebm_pkt_1, 0);
        chk({tag, "_cnt"}, {out_ebm_tx_pkt_cnt, out_ebm_md_ovf_cnt}, 0);
        chk({tag, "_dcnt"}, out_ebm_discard_cnt, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // packet buffer: data valid two cycles after the read strobe
    always @(posedge clk) begin
        a1    <= out_ebm_buf_rd_addr;
        rdata <= word(a1[13:7], a1[6:0]);
    end
    assign in_ebm_buf_rd_data = rdata;

    // output monitor: pops the scoreboard on every word and free
    always @(negedge clk) begin
        if (out_ebm_buf_rd && !rd_prev) rd_start = cyc;
        rd_prev = out_ebm_buf_rd;
        if (rst_n) begin
            if (out_ebm_pkt_0_wr) begin
                chk("p0_q", exp0.size() != 0, 1);
                chk("p0_excl", out_ebm_pkt_1_wr, 0);
                if (exp0.size() != 0) chk("p0_word", out_ebm_pkt_0, exp0.pop_front());
                w0++;
                if (out_ebm_pkt_0[133:132] == 2'b01) head_cyc = cyc;
                if (out_ebm_pkt_0[133:132] == 2'b10) tail_cyc = cyc;
            end
            if (out_ebm_pkt_1_wr) begin
                chk("p1_q", exp1.size() != 0, 1);
                if (exp1.size() != 0) chk("p1_word", out_ebm_pkt_1, exp1.pop_front());
                w1++;
                if (out_ebm_pkt_1[133:132] == 2'b01) head_cyc = cyc;
                if (out_ebm_pkt_1[133:132] == 2'b10) tail_cyc = cyc;
            end
            if (out_ebm_pkt_valid) chk("valid_free", out_ebm_buf_free_wr, 1);
            if (out_ebm_buf_free_wr) begin
                logic [7:0] e;
                chk("free_q", expf.size() != 0, 1);
                if (expf.size() != 0) begin
                    e = expf.pop_front();
                    chk("free_id", out_ebm_buf_free_id, e[6:0]);
                    chk("pkt_valid", out_ebm_pkt_valid, e[7]);
                end
                free_cyc = cyc;
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) blen[i] = 4;
        repeat (3) @(negedge clk);
        chk_rst("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4-word packet on port 0 with exact latencies
        push_pkt(7'd5, 1'b0, 1'b0);
        send(8'h05, 1'b0);
        t = t_md;
        stop();
        wait_drain("t1_drain");
        chk("t1_rd", rd_start, t + 2);
        chk("t1_head", head_cyc, t + 5);
        chk("t1_tail", tail_cyc, t + 8);
        chk("t1_free", free_cyc, t + 10);
        chk("t1_w0", w0, 4);
        chk("t1_tx", out_ebm_tx_pkt_cnt, tx_exp);

        // bandwidth discard: free only
        push_pkt(7'd3, 1'b1, 1'b1);
        send(8'h83, 1'b1);
        t = t_md;
        stop();
        wait_drain("t2_drain");
        chk("t2_free", free_cyc, t + 2);
        chk("t2_w1", w1, 0);
        chk("t2_disc", out_ebm_discard_cnt, disc_exp);

        // start threshold on port 1
        pktout_usedw_1 = 8'd200;
        blen[1] = 5;
        push_pkt(7'd1, 1'b1, 1'b0);
        send(8'h81, 1'b0);
        stop();
        repeat (10) @(negedge clk);
        chk("t3_held", w1, 0);
        chk("t3_held_q", expf.size(), 1);
        pktout_usedw_1 = 8'd100;
        tu = cyc;
        wait_drain("t3_drain");
        chk("t3_rd", rd_start, tu + 1);
        chk("t3_head", head_cyc, tu + 4);
        chk("t3_w1", w1, 5);
        chk("t3_w0", w0, 4);

        // FIFO overflow while blocked, then in-order release
        pktout_usedw_0 = 8'd200;
        for (int i = 0; i < 9; i++) begin
            blen[30 + i] = 2 + i % 4;
            if (i < 8) push_pkt(7'(30 + i), 1'b0, 1'b0);
            send({1'b0, 7'(30 + i)}, 1'b0);
        end
        stop();
        ovf_exp++;
        repeat (5) @(negedge clk);
        chk("t4_ovf", out_ebm_md_ovf_cnt, ovf_exp);
        @(negedge clk);
        pktout_usedw_0 = 8'd0;
        wait_drain("t4_drain");
        chk("t4_tx", out_ebm_tx_pkt_cnt, tx_exp);

        // buffer with no tail in 128 words
        blen[7] = 0;
        w1 = 0;
        push_pkt(7'd7, 1'b1, 1'b0);
        send(8'h87, 1'b0);
        stop();
        wait_drain("t5_drain");
        chk("t5_w1", w1, 128);

        // back-to-back mix of ports and discards
        for (int i = 0; i < 6; i++) begin
            blen[40 + i] = 2 + i;
            push_pkt(7'(40 + i), 1'(i % 2), 1'(i == 2 || i == 4));
            send({1'(i % 2), 7'(40 + i)}, 1'(i == 2 || i == 4));
        end
        stop();
        wait_drain("t6_drain");
        chk("t6_tx", out_ebm_tx_pkt_cnt, tx_exp);
        chk("t6_disc", out_ebm_discard_cnt, disc_exp);

        // reset in the middle of a packet
        blen[20] = 60;
        push_pkt(7'd20, 1'b0, 1'b0);
        send(8'h14, 1'b0);
        stop();
        repeat (20) @(negedge clk);
        chk("t7_busy", exp0.size() != 0, 1);
        #2 rst_n = 1'b0;
        #1 chk_rst("t7_rst");
        exp0.delete();
        exp1.delete();
        expf.delete();
        tx_exp = 0;
        disc_exp = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        blen[21] = 4;
        push_pkt(7'd21, 1'b0, 1'b0);
        send(8'h15, 1'b0);
        t = t_md;
        stop();
        wait_drain("t7_drain");
        chk("t7_head", head_cyc, t + 5);
        chk("t7_tx", out_ebm_tx_pkt_cnt, tx_exp);
        chk("t7_ovf", out_ebm_md_ovf_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
